// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity modes and default
// baud/oversample settings common to the RX and TX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DELIVER,
    ST_BREAK
  } rx_state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int unsigned DEF_CLK_DIV    = 54;
  localparam int unsigned DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running modulo-CLK_DIV counter that pulses
// tick for one clk when the counter reaches CLK_DIV-1.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter wraps to zero after CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line synchronizer, start/data/parity/stop FSM timed
// from the oversample tick, and a one-entry holding register with valid/ready.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = PAR_EVEN,
  parameter int unsigned STOP_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 busy
);

  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS + 1);
  localparam logic [OSW-1:0] OS_MID    = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  logic                 sync1, sync2;
  logic                 tick;
  rx_state_e            state, state_nxt;
  logic [OSW-1:0]       os_cnt, os_nxt;
  logic [BCW-1:0]       bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 deliver;
  logic                 accept;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= serial;
      sync2 <= sync1;
    end
  end

  // FSM state, counters and frame datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      perr    <= perr_nxt;
      ferr    <= ferr_nxt;
    end
  end

  // Next-state and datapath updates; line samples happen only on tick cycles.
  always_comb begin
    state_nxt = state;
    os_nxt    = os_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    deliver   = 1'b0;
    if (!rx_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && !sync2) begin
            state_nxt = ST_START;
            os_nxt    = '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (os_cnt == OS_MID) begin
              os_nxt = '0;
              if (sync2) begin
                state_nxt = ST_IDLE;
              end else begin
                state_nxt = ST_DATA;
                bit_nxt   = '0;
                perr_nxt  = 1'b0;
                ferr_nxt  = 1'b0;
              end
            end else begin
              os_nxt = os_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_nxt    = '0;
              shift_nxt = {sync2, shift[DATA_BITS-1:1]};
              bit_nxt   = bit_cnt + 1'b1;
              if (bit_cnt == DATA_LAST) begin
                bit_nxt   = '0;
                state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
              end
            end else begin
              os_nxt = os_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_nxt    = '0;
              perr_nxt  = (^shift) ^ sync2 ^ PARITY_ODD;
              state_nxt = ST_STOP;
            end else begin
              os_nxt = os_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_nxt   = '0;
              ferr_nxt = ferr | ~sync2;
              bit_nxt  = bit_cnt + 1'b1;
              if (bit_cnt == STOP_LAST) state_nxt = ST_DELIVER;
            end else begin
              os_nxt = os_cnt + 1'b1;
            end
          end
        end
        ST_DELIVER: begin
          deliver   = 1'b1;
          state_nxt = ((shift == '0) && ferr) ? ST_BREAK : ST_IDLE;
        end
        ST_BREAK: begin
          if (tick && sync2) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign accept = !rx_valid || rx_ready;

  // Holding register: load on delivery when free or draining, else flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (deliver && accept) begin
        rx_data       <= shift;
        rx_parity_err <= perr;
        rx_frame_err  <= ferr;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (deliver && !accept) overrun <= 1'b1;
      else if (ovr_clr)       overrun <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (CLK_DIV=4, OVERSAMPLE=16, 8E2) plus an
// odd-parity instance sharing the same line for the parity-mode check.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial = 1'b1;
  logic       rx_en = 1'b1;
  logic       rx_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid, overrun, busy;

  logic       ready_o = 1'b1;
  logic [7:0] data_o;
  logic       perr_o, ferr_o, valid_o, ovr_o, busy_o;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_rise = 0;
  int exp_deliver = 0;
  int rise_cnt = 0;
  int last_rise = -1;
  logic prev_v = 1'b0;

  uart_rx_ctrl #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .serial(serial), .rx_en(rx_en),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
    .ovr_clr(ovr_clr), .busy(busy)
  );

  uart_rx_ctrl #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)
  ) dut_odd (
    .clk(clk), .rst(rst), .serial(serial), .rx_en(rx_en),
    .rx_data(data_o), .rx_parity_err(perr_o), .rx_frame_err(ferr_o),
    .rx_valid(valid_o), .rx_ready(ready_o), .overrun(ovr_o),
    .ovr_clr(ovr_clr), .busy(busy_o)
  );

  always #5 clk = ~clk;

  // Cycle index aligned with the DUT tick divider (both cleared by rst).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Records each rising edge of rx_valid and the cycle it appeared in.
  always @(negedge clk) begin
    if (rx_valid && !prev_v) begin
      rise_cnt  = rise_cnt + 1;
      last_rise = cyc;
    end
    prev_v = rx_valid;
  end

  // Drives one 8-bit frame at 64 clk per bit, then 100 idle clk.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    int a;
    int t0;
    @(negedge clk);
    serial = 1'b0;
    a = cyc;
    t0 = a + 2;
    while (t0 % 4 != 3) t0++;
    exp_deliver = t0 + 737;
    exp_rise    = t0 + 738;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial = d[i];
      repeat (64) @(negedge clk);
    end
    serial = p;
    repeat (64) @(negedge clk);
    serial = s1;
    repeat (64) @(negedge clk);
    serial = s2;
    repeat (64) @(negedge clk);
    serial = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic pulse_ready();
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_run++; if ({rx_data, rx_parity_err, rx_frame_err, rx_valid, overrun, busy} !== 13'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h exp 0", {rx_data, rx_parity_err, rx_frame_err, rx_valid, overrun, busy});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int r0;
    r0 = rise_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    n_run++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b exp 1", rx_valid); end
    n_run++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL t1_data: got %h exp a5", rx_data); end
    n_run++; if ({rx_parity_err, rx_frame_err} !== 2'b00) begin n_fail++; $display("FAIL t1_errs: got %b exp 00", {rx_parity_err, rx_frame_err}); end
    n_run++; if (last_rise !== exp_rise) begin n_fail++; $display("FAIL t1_latency: got cycle %0d exp %0d", last_rise, exp_rise); end
    n_run++; if (rise_cnt - r0 !== 1) begin n_fail++; $display("FAIL t1_deliveries: got %0d exp 1", rise_cnt - r0); end
    repeat (50) @(negedge clk);
    n_run++; if ({rx_valid, rx_data} !== 9'h1A5) begin n_fail++; $display("FAIL t1_hold: got %h exp 1a5", {rx_valid, rx_data}); end
    rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    n_run++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL t1_consume: got %b exp 0", rx_valid); end
  endtask

  task automatic test_parity();
    ready_o = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    n_run++; if ({rx_valid, rx_data, rx_parity_err, rx_frame_err} !== 11'b1_00000001_10) begin
      n_fail++; $display("FAIL t2_even_perr: got %b exp 10000000110", {rx_valid, rx_data, rx_parity_err, rx_frame_err});
    end
    n_run++; if ({valid_o, data_o, perr_o} !== 10'b1_00000001_0) begin
      n_fail++; $display("FAIL t2_odd_perr: got %b exp 1000000010", {valid_o, data_o, perr_o});
    end
    ready_o = 1'b1;
    pulse_ready();
  endtask

  task automatic test_glitch();
    int r0;
    r0 = rise_cnt;
    @(negedge clk) serial = 1'b0;
    repeat (12) @(negedge clk);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t3_busy_start: got %b exp 1", busy); end
    serial = 1'b1;
    repeat (64) @(negedge clk);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy_idle: got %b exp 0", busy); end
    n_run++; if (rx_valid !== 1'b0 || rise_cnt != r0) begin
      n_fail++; $display("FAIL t3_no_delivery: got valid %b rises %0d exp 0 0", rx_valid, rise_cnt - r0);
    end
  endtask

  task automatic test_framing_break();
    int r0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    n_run++; if ({rx_valid, rx_data, rx_parity_err, rx_frame_err} !== 11'b1_00111100_01) begin
      n_fail++; $display("FAIL t4_ferr: got %b exp 10011110001", {rx_valid, rx_data, rx_parity_err, rx_frame_err});
    end
    pulse_ready();
    repeat (20) @(negedge clk);
    r0 = rise_cnt;
    serial = 1'b0;
    repeat (20 * 64) @(negedge clk);
    n_run++; if (rise_cnt - r0 !== 1) begin n_fail++; $display("FAIL t4_break_count: got %0d exp 1", rise_cnt - r0); end
    n_run++; if ({rx_data, rx_parity_err, rx_frame_err, overrun} !== 11'b00000000_010) begin
      n_fail++; $display("FAIL t4_break_data: got %b exp 00000000010", {rx_data, rx_parity_err, rx_frame_err, overrun});
    end
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t4_break_busy: got %b exp 1", busy); end
    serial = 1'b1;
    repeat (12) @(negedge clk);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_break_exit: got %b exp 0", busy); end
    pulse_ready();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    n_run++; if ({rx_valid, rx_data, rx_parity_err, rx_frame_err} !== 11'b1_01011010_00) begin
      n_fail++; $display("FAIL t4_after_break: got %b exp 10101101000", {rx_valid, rx_data, rx_parity_err, rx_frame_err});
    end
    pulse_ready();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    n_run++; if ({rx_valid, rx_data, overrun} !== 10'b1_00010001_1) begin
      n_fail++; $display("FAIL t5_overrun: got %b exp 1000100011", {rx_valid, rx_data, overrun});
    end
    @(negedge clk) ovr_clr = 1'b1;
    @(negedge clk) ovr_clr = 1'b0;
    n_run++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL t5_ovr_clr: got %b exp 0", overrun); end
    fork
      send_frame(8'h22, 1'b0, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 1000; k++) begin
          @(negedge clk);
          if (cyc == exp_deliver) begin
            rx_ready = 1'b1;
            @(negedge clk) rx_ready = 1'b0;
            break;
          end
        end
      end
    join
    n_run++; if ({rx_valid, rx_data, overrun} !== 10'b1_00100010_0) begin
      n_fail++; $display("FAIL t5_ready_in_deliver: got %b exp 1001000100", {rx_valid, rx_data, overrun});
    end
  endtask

  task automatic test_abort();
    int r0;
    @(negedge clk) serial = 1'b0;
    repeat (64) @(negedge clk);
    serial = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_run++; if ({rx_data, rx_parity_err, rx_frame_err, rx_valid, overrun, busy} !== 13'h0) begin
      n_fail++; $display("FAIL t6_rst_mid: got %h exp 0", {rx_data, rx_parity_err, rx_frame_err, rx_valid, overrun, busy});
    end
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    n_run++; if ({rx_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL t6_rst_quiet: got %b exp 00", {rx_valid, busy}); end
    send_frame(8'h96, 1'b0, 1'b1, 1'b1);
    n_run++; if ({rx_valid, rx_data, rx_parity_err, rx_frame_err} !== 11'b1_10010110_00) begin
      n_fail++; $display("FAIL t6_after_rst: got %b exp 11001011000", {rx_valid, rx_data, rx_parity_err, rx_frame_err});
    end
    r0 = rise_cnt;
    @(negedge clk) serial = 1'b0;
    repeat (64) @(negedge clk);
    serial = 1'b1;
    repeat (100) @(negedge clk);
    rx_en = 1'b0;
    @(negedge clk);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_en_abort: got %b exp 0", busy); end
    repeat (2) @(negedge clk);
    rx_en = 1'b1;
    repeat (1000) @(negedge clk);
    n_run++; if ({rx_valid, rx_data, overrun} !== 10'b1_10010110_0) begin
      n_fail++; $display("FAIL t6_en_hold: got %b exp 1100101100", {rx_valid, rx_data, overrun});
    end
    n_run++; if (rise_cnt != r0) begin n_fail++; $display("FAIL t6_en_nodeliver: got %0d exp 0", rise_cnt - r0); end
    pulse_ready();
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
    n_run++; if ({rx_valid, rx_data, rx_parity_err, rx_frame_err} !== 11'b1_11000011_00) begin
      n_fail++; $display("FAIL t6_final: got %b exp 11100001100", {rx_valid, rx_data, rx_parity_err, rx_frame_err});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_glitch();
    test_framing_break();
    test_overrun();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
